// File: rtl/iir_inv.sv
// iir_inv: inverse of the second-order recursive IIR, x[n] = y[n] - A1*y[n-1] - A2*y[n-2].
// Two-stage valid/ready pipeline; define IIR_INV_SAT_EN to saturate the result instead of wrapping.
module iir_inv #(
  parameter int NB_DATA = 8,
  parameter int A1      = 1,
  parameter int A2      = 0,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_clear,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_primed,
  output logic [NB_CNT-1:0]  o_count
);

  localparam int W = NB_DATA + 5;
  localparam logic signed [W-1:0] C1 = W'(A1);
  localparam logic signed [W-1:0] C2 = W'(A2);

  // Each bit of the state is the valid flag of one stage: [1] output stage, [0] stage 1.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_ONE_IN  = 2'b01,
    OCC_ONE_OUT = 2'b10,
    OCC_TWO     = 2'b11
  } occ_t;

  occ_t                state;
  occ_t                state_next;
  logic                s1_valid;
  logic                adv;
  logic                accept;
  logic [NB_DATA-1:0]  y1;
  logic [NB_DATA-1:0]  y2;
  logic signed [W-1:0] s1_y;
  logic signed [W-1:0] s1_p1;
  logic signed [W-1:0] s1_p2;
  logic signed [W-1:0] diff;
  logic [NB_DATA-1:0]  result;

  function automatic logic signed [W-1:0] sext(input logic [NB_DATA-1:0] v);
    return {{(W-NB_DATA){v[NB_DATA-1]}}, v};
  endfunction

  assign s1_valid = state[0];
  assign o_valid  = state[1];
  assign adv      = !o_valid || i_ready;
  assign o_ready  = adv && !i_clear && i_rst;
  assign accept   = i_valid && o_ready;
  assign o_primed = (o_count >= NB_CNT'(2));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (i_clear) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY:   if (accept) state_next = OCC_ONE_IN;
        OCC_ONE_IN:  state_next = accept ? OCC_TWO : OCC_ONE_OUT;
        OCC_ONE_OUT: if (i_ready) state_next = accept ? OCC_ONE_IN : OCC_EMPTY;
        OCC_TWO:     if (i_ready) state_next = accept ? OCC_TWO : OCC_ONE_OUT;
        default:     state_next = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear) begin
      y1      <= '0;
      y2      <= '0;
      o_count <= '0;
    end else if (accept) begin
      y2 <= y1;
      y1 <= i_data;
      if (o_count != '1) o_count <= o_count + NB_CNT'(1);
    end
  end

  // NOTE: stage-1 datapath has no reset; the occupancy state alone says whether it holds a live sample.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_y  <= sext(i_data);
      s1_p1 <= C1 * sext(y1);
      s1_p2 <= C2 * sext(y2);
    end
  end

  assign diff = s1_y - s1_p1 - s1_p2;

`ifdef IIR_INV_SAT_EN
  localparam logic signed [W-1:0] SAT_MAX = W'((2 ** (NB_DATA - 1)) - 1);
  localparam logic signed [W-1:0] SAT_MIN = W'(-(2 ** (NB_DATA - 1)));

  always_comb begin
    result = diff[NB_DATA-1:0];
    if (diff > SAT_MAX) begin
      result = SAT_MAX[NB_DATA-1:0];
    end else if (diff < SAT_MIN) begin
      result = SAT_MIN[NB_DATA-1:0];
    end
  end
`else
  // Wrapping keeps only the low bits; the guard bits are deliberately dropped.
  logic diff_unused_hi;
  assign diff_unused_hi = ^diff[W-1:NB_DATA];
  assign result         = diff[NB_DATA-1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data <= '0;
    end else if (adv && s1_valid) begin
      o_data <= result;
    end
  end

endmodule

// File: tb/tb_iir_inv.sv
// Self-checking bench for iir_inv: scoreboard model of x = y - A1*y1 - A2*y2 plus directed literal checks.
// Two instances: channel 0 (A1=1, A2=0, 16-bit count) and channel 1 (A1=1, A2=-1, 3-bit count).
module tb_iir_inv;

  localparam int NB_DATA  = 8;
  localparam int NB_CNT   = 16;
  localparam int NB_CNT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clear;
  logic        ready;
  logic        valid;
  logic [7:0]  din;
  logic        o_ready;
  logic        o_valid;
  logic        o_primed;
  logic [7:0]  o_data;
  logic [15:0] o_count;
  logic        valid_b;
  logic [7:0]  din_b;
  logic        o_ready_b;
  logic        o_valid_b;
  logic        o_primed_b;
  logic [7:0]  o_data_b;
  logic [2:0]  o_count_b;

  iir_inv #(.NB_DATA(NB_DATA), .A1(1), .A2(0), .NB_CNT(NB_CNT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(valid), .o_ready(o_ready),
    .i_clear(clear), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_primed(o_primed), .o_count(o_count)
  );

  iir_inv #(.NB_DATA(NB_DATA), .A1(1), .A2(-1), .NB_CNT(NB_CNT_B)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(din_b), .i_valid(valid_b), .o_ready(o_ready_b),
    .i_clear(clear), .o_data(o_data_b), .o_valid(o_valid_b), .i_ready(ready),
    .o_primed(o_primed_b), .o_count(o_count_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: signed samples, integer products, then wrap or clamp to 8 bits.
  function automatic logic [7:0] model_x(input int a1, input int a2,
                                         input logic [7:0] y, input logic [7:0] y1,
                                         input logic [7:0] y2);
    int s;
    s = int'($signed(y)) - a1 * int'($signed(y1)) - a2 * int'($signed(y2));
`ifdef IIR_INV_SAT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] h1[2] = '{8'd0, 8'd0};
  logic [7:0] h2[2] = '{8'd0, 8'd0};
  int         mcnt[2] = '{0, 0};
  int         cyc = 0;
  int         first_acc = -1;
  int         first_val = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] e;

  always @(posedge clk) cyc++;

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    check("ch0 count", o_count, mcnt[0]);
    check("ch0 primed", o_primed, mcnt[0] >= 2);
    check("ch1 count", o_count_b, mcnt[1]);
    check("ch1 primed", o_primed_b, mcnt[1] >= 2);
    check("ch0 o_ready", o_ready, (!o_valid || ready) && !clear && rst);
    check("ch1 o_ready", o_ready_b, (!o_valid_b || ready) && !clear && rst);
    if (prev_stall) begin
      check("ch0 stall valid", o_valid, 1);
      check("ch0 stall data", o_data, prev_data);
    end
    prev_stall = o_valid && !ready && rst && !clear;
    prev_data  = o_data;

    if (!rst || clear) begin
      exp0.delete();
      exp1.delete();
      h1   = '{8'd0, 8'd0};
      h2   = '{8'd0, 8'd0};
      mcnt = '{0, 0};
    end else begin
      if (o_valid && first_val < 0) first_val = cyc;
      if (o_valid && ready) begin
        check("ch0 output expected", exp0.size() > 0, 1);
        if (exp0.size() > 0) begin
          e = exp0.pop_front();
          check("ch0 data", o_data, e);
          got0.push_back(o_data);
        end
      end
      if (o_valid_b && ready) begin
        check("ch1 output expected", exp1.size() > 0, 1);
        if (exp1.size() > 0) begin
          e = exp1.pop_front();
          check("ch1 data", o_data_b, e);
          got1.push_back(o_data_b);
        end
      end
      if (valid && o_ready) begin
        if (first_acc < 0) first_acc = cyc;
        exp0.push_back(model_x(1, 0, din, h1[0], h2[0]));
        h2[0] = h1[0];
        h1[0] = din;
        if (mcnt[0] < (1 << NB_CNT) - 1) mcnt[0]++;
      end
      if (valid_b && o_ready_b) begin
        exp1.push_back(model_x(1, -1, din_b, h1[1], h2[1]));
        h2[1] = h1[1];
        h1[1] = din_b;
        if (mcnt[1] < (1 << NB_CNT_B) - 1) mcnt[1]++;
      end
    end
  end

  task automatic send0(input logic [7:0] d);
    bit ok = 0;
    valid = 1'b1;
    din   = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (o_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    check("ch0 send accepted", ok, 1);
  endtask

  task automatic send1(input logic [7:0] d);
    bit ok = 0;
    valid_b = 1'b1;
    din_b   = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (o_ready_b) ok = 1;
      @(posedge clk);
      #1;
    end
    valid_b = 1'b0;
    check("ch1 send accepted", ok, 1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(posedge clk);
      #2;
      if (exp0.size() == 0 && exp1.size() == 0) done = 1;
    end
    check("drain within budget", done, 1);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  logic [7:0] exp_imp[5] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd0};
  logic [7:0] exp_so[3]  = '{8'd2, 8'd1, 8'd0};
  logic [7:0] exp_bp[4]  = '{8'd10, 8'd15, 8'd2, 8'd13};
  logic [7:0] wrap_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; clear = 1'b0; ready = 1'b1;
    valid = 1'b0; din = 8'd0; valid_b = 1'b0; din_b = 8'd0;
`ifdef IIR_INV_SAT_EN
    wrap_exp = 8'h80;
`else
    wrap_exp = 8'h7F;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_valid", o_valid, 0);
    check("reset o_ready", o_ready, 0);
    check("reset o_data", o_data, 0);
    check("reset o_count", o_count, 0);
    check("reset o_primed", o_primed, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Impulse-style stream, A1=1 A2=0
    got0.delete();
    first_acc = -1;
    first_val = -1;
    send0(8'd1); send0(8'd3); send0(8'd4); send0(8'd6); send0(8'd6);
    wait_drain();
    check("impulse n", got0.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got0.size()) check("impulse value", got0[i], exp_imp[i]);
    check("impulse latency", first_val - first_acc, 2);
    check("impulse count", o_count, 5);
    check("impulse primed", o_primed, 1);

    // Second order on channel 1, then drive its 3-bit counter into saturation
    got1.delete();
    send1(8'd2); send1(8'd3); send1(8'd1);
    wait_drain();
    check("second order n", got1.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got1.size()) check("second order value", got1[i], exp_so[i]);
    repeat (6) send1(8'h10);
    wait_drain();
    check("ch1 count saturated", o_count_b, 7);
    check("ch1 primed", o_primed_b, 1);

    // Backpressure: three stalled cycles in the middle of a stream
    clear_pulse();
    got0.delete();
    fork
      begin
        send0(8'd10); send0(8'd25); send0(8'd27); send0(8'd40);
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp o_ready low", o_ready, 0);
          check("bp o_valid held", o_valid, 1);
        end
        @(posedge clk);
        #1 ready = 1'b1;
      end
    join
    wait_drain();
    check("bp n", got0.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got0.size()) check("bp value", got0[i], exp_bp[i]);

    // Clear with an output pending and a valid input presented
    clear_pulse();
    got0.delete();
    ready = 1'b0;
    send0(8'd5); send0(8'd7);
    @(negedge clk);
    check("clr pending valid", o_valid, 1);
    check("clr pending data", o_data, 5);
    @(posedge clk);
    #1;
    clear = 1'b1; valid = 1'b1; din = 8'd99; ready = 1'b1;
    @(negedge clk);
    check("clr o_ready", o_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("clr o_valid", o_valid, 0);
    check("clr o_count", o_count, 0);
    check("clr o_primed", o_primed, 0);
    @(posedge clk);
    #1;
    send0(8'd9);
    wait_drain();
    check("clr n", got0.size(), 1);
    if (got0.size() > 0) check("clr after value", got0[0], 9);

    // Overflow: wrap or saturate depending on the build
    clear_pulse();
    got0.delete();
    send0(8'h01); send0(8'h80);
    wait_drain();
    check("wrap n", got0.size(), 2);
    if (got0.size() > 1) begin
      check("wrap first", got0[0], 8'h01);
      check("wrap second", got0[1], wrap_exp);
    end

    // Reset during a stall
    ready = 1'b0;
    send0(8'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst-mid pending", o_valid, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst-mid o_valid", o_valid, 0);
    check("rst-mid o_count", o_count, 0);
    @(posedge clk);
    #1 ready = 1'b1;
    got0.delete();
    send0(8'd4);
    wait_drain();
    check("rst-mid n", got0.size(), 1);
    if (got0.size() > 0) check("rst-mid value", got0[0], 4);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
